regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (WriteRegister/WriteData/RegWrite, written on posedge Clk) between NREQ writeback requesters, e.g. ALU and load unit.
- Round-robin grant with valid/ready handshake per requester.
- Registered output stage drives the register file directly.
- Writes to register 0 are accepted but suppressed.

---
 rtl/wbarb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wbarb_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
package wbarb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DROP_W     = 8;

  localparam logic [4:0]        REG_ZERO = 5'd0;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  // Saturating increment for the dropped-write counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with a rotating priority pointer; no grant under hold or reset.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant_c
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  int unsigned      pos;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_c = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    pos     = 0;
    if (rst_n && !hold) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        pos = 32'(ptr_q) + off;
        if (pos >= NREQ) pos = pos - NREQ;
        idx = PTR_W'(pos);
        if ((grant_c == '0) && req[idx]) begin
          grant_c[idx] = 1'b1;
          ptr_d        = (pos == NREQ - 1) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ requesters with a registered output stage.
// Optional read bypass ports are enabled by defining WBARB_BYPASS_EN.
module regfile_write_arbiter
  import wbarb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Hold,
  input  logic [NREQ-1:0]        ReqValid,
  input  logic [NREQ*ADDR_W-1:0] ReqAddr,
  input  logic [NREQ*DATA_W-1:0] ReqData,
  output logic [NREQ-1:0]        ReqReady,
  output logic [ADDR_W-1:0]      WriteRegister,
  output logic [DATA_W-1:0]      WriteData,
  output logic                   RegWrite,
`ifdef WBARB_BYPASS_EN
  input  logic [ADDR_W-1:0]      ReadRegister1,
  input  logic [ADDR_W-1:0]      ReadRegister2,
  output logic                   BypassHit1,
  output logic                   BypassHit2,
  output logic [DATA_W-1:0]      BypassData,
`endif
  output logic [DROP_W-1:0]      DropCount
);

  logic [NREQ-1:0]   grant_c;
  logic              transfer_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              reg_write_q, reg_write_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .hold    (Hold),
    .req     (ReqValid),
    .grant_c (grant_c)
  );

  // Mux the granted payload; register-zero writes are accepted but only counted.
  always_comb begin
    sel_addr_c  = '0;
    sel_data_c  = '0;
    transfer_c  = |(grant_c & ReqValid);
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_write_d = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_addr_c = ReqAddr[i*ADDR_W +: ADDR_W];
        sel_data_c = ReqData[i*DATA_W +: DATA_W];
      end
    end
    if (transfer_c) begin
      if (sel_addr_c != ADDR_W'(REG_ZERO)) begin
        wr_addr_d   = sel_addr_c;
        wr_data_d   = sel_data_c;
        reg_write_d = 1'b1;
      end else begin
        drop_cnt_d  = sat_inc(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign ReqReady      = grant_c;
  assign WriteRegister = wr_addr_q;
  assign WriteData     = wr_data_q;
  assign RegWrite      = reg_write_q;
  assign DropCount     = drop_cnt_q;

`ifdef WBARB_BYPASS_EN
  // Forward the staged write to readers one cycle before the register file holds it.
  assign BypassHit1 = reg_write_q & (ReadRegister1 == wr_addr_q) & (wr_addr_q != ADDR_W'(REG_ZERO));
  assign BypassHit2 = reg_write_q & (ReadRegister2 == wr_addr_q) & (wr_addr_q != ADDR_W'(REG_ZERO));
  assign BypassData = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a modelled register file behind it.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic                 Clk = 1'b0;
  logic                 Reset_n;
  logic                 Hold;
  logic [NREQ-1:0]      ReqValid;
  logic [NREQ*AW-1:0]   ReqAddr;
  logic [NREQ*DW-1:0]   ReqData;
  logic [NREQ-1:0]      ReqReady;
  logic [AW-1:0]        WriteRegister;
  logic [DW-1:0]        WriteData;
  logic                 RegWrite;
  logic [7:0]           DropCount;
`ifdef WBARB_BYPASS_EN
  logic [AW-1:0]        ReadRegister1 = '0;
  logic [AW-1:0]        ReadRegister2 = '0;
  logic                 BypassHit1, BypassHit2;
  logic [DW-1:0]        BypassData;
`endif

  regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Hold          (Hold),
    .ReqValid      (ReqValid),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .ReqReady      (ReqReady),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
`ifdef WBARB_BYPASS_EN
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .BypassHit1    (BypassHit1),
    .BypassHit2    (BypassHit2),
    .BypassData    (BypassData),
`endif
    .DropCount     (DropCount)
  );

  always #5 Clk = ~Clk;

  // Register file fed by the arbiter; r0 never written.
  logic [DW-1:0] rf [32];
  initial for (int k = 0; k < 32; k++) rf[k] = '0;
  always @(posedge Clk) if (RegWrite && WriteRegister != '0) rf[WriteRegister] <= WriteData;

  int   n_total = 0;
  int   n_bad   = 0;
  int   mptr    = 0;
  logic [7:0] mdrop = '0;
  wr_t  sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic h, input int p);
    if (h) return 2'b00;
    for (int off = 0; off < 2; off++) begin
      int idx;
      idx = (p + off) % 2;
      if (v[idx]) return (idx == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic check_out();
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("regwrite", 64'(RegWrite), 64'd1);
      check_eq("wreg", 64'(WriteRegister), 64'(e.a));
      check_eq("wdata", 64'(WriteData), 64'(e.d));
    end else begin
      check_eq("regwrite_idle", 64'(RegWrite), 64'd0);
    end
    check_eq("dropcnt", 64'(DropCount), 64'(mdrop));
  endtask

  // One clock: present inputs, check the grant, model the edge, check the staged write.
  task automatic drive(input logic [1:0] v, input logic h,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    wr_t w;
    ReqValid = v;
    Hold     = h;
    ReqAddr  = {a1, a0};
    ReqData  = {d1, d0};
    #1;
    g = exp_grant(v, h, mptr);
    check_eq("ready", 64'(ReqReady), 64'(g));
    @(posedge Clk);
    if (g != 2'b00) begin
      mptr = g[1] ? 0 : 1;
      a = g[1] ? a1 : a0;
      d = g[1] ? d1 : d0;
      if (a != '0) begin
        w.a = a;
        w.d = d;
        sb.push_back(w);
      end else if (mdrop != 8'd255) begin
        mdrop = mdrop + 8'd1;
      end
    end
    #1;
    check_out();
  endtask

  task automatic idle();
    drive(2'b00, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    Hold     = 1'b0;
    ReqValid = 2'b11;
    ReqAddr  = {5'd3, 5'd4};
    ReqData  = {32'd1, 32'd2};
    #2;
    check_eq("rst_ready", 64'(ReqReady), 64'd0);
    check_eq("rst_regwrite", 64'(RegWrite), 64'd0);
    check_eq("rst_wreg", 64'(WriteRegister), 64'd0);
    check_eq("rst_wdata", 64'(WriteData), 64'd0);
    check_eq("rst_drop", 64'(DropCount), 64'd0);
    ReqValid = 2'b00;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check_out();
    idle();

    // Single writer.
    drive(2'b01, 1'b0, 5'd2, 32'd42, '0, '0);
    idle();
    check_eq("rf_r2", 64'(rf[2]), 64'd42);

    // B alone brings the pointer back to A, then contention alternates A,B,A,B.
    drive(2'b10, 1'b0, '0, '0, 5'd3, 32'd7);
    for (int k = 0; k < 4; k++) drive(2'b11, 1'b0, 5'd1, 32'd8, 5'd2, 32'd11);
    idle();
    check_eq("rf_r1", 64'(rf[1]), 64'd8);
    check_eq("rf_r2b", 64'(rf[2]), 64'd11);

    // Same-address collision with pointer at A, then at B.
    drive(2'b11, 1'b0, 5'd5, 32'd15, 5'd5, 32'd99);
    drive(2'b10, 1'b0, 5'd5, 32'd15, 5'd5, 32'd99);
    idle();
    check_eq("rf_r5_p0", 64'(rf[5]), 64'd99);
    drive(2'b01, 1'b0, 5'd6, 32'd1, '0, '0);
    drive(2'b11, 1'b0, 5'd5, 32'd15, 5'd5, 32'd99);
    drive(2'b01, 1'b0, 5'd5, 32'd15, 5'd5, 32'd99);
    idle();
    check_eq("rf_r5_p1", 64'(rf[5]), 64'd15);

    // Register-zero writes are dropped and counted with saturation.
    drive(2'b01, 1'b0, 5'd0, 32'd8, '0, '0);
    check_eq("drop_one", 64'(DropCount), 64'd1);
    idle();
    check_eq("rf_r0", 64'(rf[0]), 64'd0);
    for (int k = 0; k < 299; k++) drive(2'b01, 1'b0, 5'd0, 32'd8, '0, '0);
    check_eq("drop_sat", 64'(DropCount), 64'd255);

    // Hold blocks grants; release grants on the next cycle.
    for (int k = 0; k < 3; k++) drive(2'b01, 1'b1, 5'd7, 32'd33, '0, '0);
    check_eq("rf_r7_held", 64'(rf[7]), 64'd0);
    drive(2'b01, 1'b0, 5'd7, 32'd33, '0, '0);
    idle();
    check_eq("rf_r7", 64'(rf[7]), 64'd33);

    // Reset while a write is staged loses it.
    drive(2'b01, 1'b0, 5'd9, 32'd77, '0, '0);
    ReqValid = 2'b00;
    Reset_n  = 1'b0;
    #1;
    check_eq("midrst_regwrite", 64'(RegWrite), 64'd0);
    check_eq("midrst_ready", 64'(ReqReady), 64'd0);
    check_eq("midrst_drop", 64'(DropCount), 64'd0);
    @(posedge Clk);
    #1;
    check_eq("midrst_rf_r9", 64'(rf[9]), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    mptr    = 0;
    mdrop   = '0;
    sb.delete();
    @(posedge Clk);
    #1;
    check_out();
    drive(2'b01, 1'b0, 5'd9, 32'd77, '0, '0);
    idle();
    check_eq("rf_r9", 64'(rf[9]), 64'd77);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
